// File: rtl/selector41_collect.sv
// Four-lane collector: round-robin merges iZ0..iZ3 onto one registered output
// word tagged with its source lane on {oS1,oS0}.
module selector41_collect #(
    parameter int DW = 8
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic [DW-1:0] iZ0,
    input  logic [DW-1:0] iZ1,
    input  logic [DW-1:0] iZ2,
    input  logic [DW-1:0] iZ3,
    input  logic [3:0]    iV,
    output logic [3:0]    oAck,
    output logic [DW-1:0] oC,
    output logic          oS1,
    output logic          oS0,
    output logic          oValid,
    input  logic          iReady
);

    // Handshake: a lane word moves when iV[k] && oAck[k] at an edge; an output
    // word moves downstream when oValid && iReady at an edge. A held word
    // (oValid && !iReady) keeps every output stable and acknowledges nothing.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [1:0]    sel;
    logic [1:0]    cand;
    logic          found;
    logic          anyV;
    logic          free;
    logic          load;
    logic [DW-1:0] selData;

    assign oValid = (state == FULL);
    assign anyV   = |iV;
    assign free   = !oValid || iReady;
    assign load   = free && anyV && !iRst;

    // Scan lanes starting at ptr so the lane after the last winner goes first.
    always_comb begin
        sel   = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && iV[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        selData = iZ0;
        case (sel)
            2'd0: selData = iZ0;
            2'd1: selData = iZ1;
            2'd2: selData = iZ2;
            2'd3: selData = iZ3;
            default: selData = iZ0;
        endcase
    end

    assign oAck = load ? (4'b0001 << sel) : 4'b0000;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= EMPTY;
            oC         <= '0;
            {oS1, oS0} <= 2'b00;
            ptr        <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        state      <= FULL;
                        oC         <= selData;
                        {oS1, oS0} <= sel;
                        ptr        <= sel + 2'd1;
                    end
                end
                FULL: begin
                    if (load) begin
                        oC         <= selData;
                        {oS1, oS0} <= sel;
                        ptr        <= sel + 2'd1;
                    end else if (iReady) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_selector41_collect.sv
// Directed bench for selector41_collect: hand-computed vectors checked with
// immediate assertions on the falling clock edge.
module tb_selector41_collect;

    logic       clk;
    logic       rst;
    logic [7:0] z0, z1, z2, z3;
    logic [3:0] v;
    logic [3:0] ack;
    logic [7:0] c;
    logic       s1, s0;
    logic       valid;
    logic       ready;

    int checks   = 0;
    int failures = 0;

    selector41_collect #(.DW(8)) dut (
        .iClk(clk), .iRst(rst),
        .iZ0(z0), .iZ1(z1), .iZ2(z2), .iZ3(z3),
        .iV(v), .oAck(ack), .oC(c), .oS1(s1), .oS0(s0),
        .oValid(valid), .iReady(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; registered outputs are read one
    // falling edge after the rising edge that updates them.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] expC,
                           input logic [1:0] expS, input logic expV);
        chk({tag, "_c"}, 32'(c), 32'(expC));
        chk({tag, "_s"}, 32'({s1, s0}), 32'(expS));
        chk({tag, "_valid"}, 32'(valid), 32'(expV));
    endtask

    task automatic chk_ack(input string tag, input logic [3:0] expAck);
        #1;
        chk({tag, "_ack"}, 32'(ack), 32'(expAck));
    endtask

    initial begin
        rst = 1'b1; v = 4'hF; ready = 1'b1;
        z0 = 8'h00; z1 = 8'h00; z2 = 8'h00; z3 = 8'h00;
        tick();
        chk_ack("rst_forced", 4'b0000);
        tick();
        chk_out("rst", 8'h00, 2'd0, 1'b0);

        // 1: idle after reset
        rst = 1'b0; v = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            chk_ack("idle", 4'b0000);
            tick();
            chk_out("idle", 8'h00, 2'd0, 1'b0);
        end

        // 2: single word from lane 2, then drain
        z2 = 8'hA5; v = 4'b0100; ready = 1'b1;
        chk_ack("l2", 4'b0100);
        tick();
        chk_out("l2", 8'hA5, 2'd2, 1'b1);
        v = 4'b0000;
        chk_ack("drain", 4'b0000);
        tick();
        chk_out("drain", 8'hA5, 2'd2, 1'b0);

        // 3: all lanes valid from ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        z0 = 8'h10; z1 = 8'h11; z2 = 8'h12; z3 = 8'h13; v = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            chk_ack("rr", 4'b0001 << (i % 4));
            tick();
            chk_out("rr", 8'h10 + 8'(i % 4), 2'(i % 4), 1'b1);
        end

        // 4: lane 1 load then hold for three cycles; ptr=2 afterwards
        z1 = 8'h3C; v = 4'b0010;
        chk_ack("l1", 4'b0010);
        tick();
        chk_out("l1", 8'h3C, 2'd1, 1'b1);
        ready = 1'b0; v = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            chk_ack("hold", 4'b0000);
            tick();
            chk_out("hold", 8'h3C, 2'd1, 1'b1);
        end
        ready = 1'b1;
        chk_ack("after_hold_l3", 4'b1000);
        tick();
        chk_out("after_hold_l3", 8'h13, 2'd3, 1'b1);
        chk_ack("after_hold_l0", 4'b0001);
        tick();
        chk_out("after_hold_l0", 8'h10, 2'd0, 1'b1);
        v = 4'b0000;
        tick();
        chk_out("drain2", 8'h10, 2'd0, 1'b0);

        // 5: reset discards a held word and restarts ptr at 0
        v = 4'b0001;
        tick();
        chk_out("pre_rst", 8'h10, 2'd0, 1'b1);
        v = 4'b0000; ready = 1'b0; rst = 1'b1;
        chk_ack("mid_rst", 4'b0000);
        tick();
        chk_out("mid_rst", 8'h00, 2'd0, 1'b0);
        rst = 1'b0; v = 4'b1010; ready = 1'b1;
        chk_ack("post_rst", 4'b0010);
        tick();
        chk_out("post_rst", 8'h3C, 2'd1, 1'b1);
        v = 4'b0000;
        tick();
        chk_out("drain3", 8'h3C, 2'd1, 1'b0);

        // 6: lane 0 continuous, ready toggling 1,0,1
        z0 = 8'h55; v = 4'b0001; ready = 1'b1;
        chk_ack("tog1", 4'b0001);
        tick();
        chk_out("tog1", 8'h55, 2'd0, 1'b1);
        z0 = 8'h66; ready = 1'b0;
        chk_ack("tog2", 4'b0000);
        tick();
        chk_out("tog2", 8'h55, 2'd0, 1'b1);
        ready = 1'b1;
        chk_ack("tog3", 4'b0001);
        tick();
        chk_out("tog3", 8'h66, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
